watch_datetime: RTL and testbench
=================================

WATCH_DATETIME -- requirements
Module: watch_datetime

Interface
REQ-001 SHALL have parameter YEAR_W, 12, width of year field.
REQ-002 SHALL have parameter YEAR_MIN, 1, lowest legal year and wrap target.
REQ-003 SHALL have parameter YEAR_MAX, 4095, highest legal year, at most 2^YEAR_W-1.
REQ-004 SHALL have parameters RST_YEAR/RST_MONTH/RST_DAY/RST_DOW, 2021/5/30/0, the reset date and weekday (0=Sunday).
REQ-005 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port clk1sec  input  1  one-cycle-wide enable, one per second.
REQ-008 SHALL have port set_time  input  1  load request for bin_time.
REQ-009 SHALL have port bin_time  input  YEAR_W+40  packed {year, month, day, hour, minute, second}, 8 bits each except year.
REQ-010 SHALL have port set_dow  input  3  weekday loaded with bin_time.
REQ-011 SHALL have port alarm_load  input  1  load request for alarm_time.
REQ-012 SHALL have port alarm_time  input  24  packed {hour, minute, second}.
REQ-013 SHALL have port alarm_en  input  1  alarm pulse enable.
REQ-014 SHALL have ports year (YEAR_W), month, day, hour, minute, second (8 each), dow (3)  output  registered current time.
REQ-015 SHALL have port set_err  output  1  one-cycle pulse, rejected set.
REQ-016 SHALL have port alarm_pulse  output  1  one-cycle pulse on alarm match.
REQ-017 SHALL have port wrap_pulse  output  1  one-cycle pulse on YEAR_MAX to YEAR_MIN rollover.

Function
REQ-018 SHALL compute leap = (year%4==0 && year%100!=0) || year%400==0; max_day = 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; 28+leap for 2.
REQ-019 SHALL treat set_time as highest priority; clk1sec in the same cycle is dropped, never deferred.
REQ-020 SHALL validate bin_time: YEAR_MIN<=year<=YEAR_MAX, 1<=month<=12, 1<=day<=max_day(bin year, bin month), hour<=23, minute<=59, second<=59, set_dow<=6.
REQ-021 SHALL, on valid set, load all fields and dow at the next edge; set_err stays 0.
REQ-022 SHALL, on invalid set, leave all time state unchanged and assert set_err for exactly the next cycle.
REQ-023 SHALL, on clk1sec with no set_time, advance one second with carry: second 59->0 carries to minute, 59->0 to hour, 23->0 to day, max_day->1 to month, 12->1 to year.
REQ-024 SHALL increment dow modulo 7 on every day carry.
REQ-025 SHALL, when year==YEAR_MAX carries, load YEAR_MIN and assert wrap_pulse for one cycle, coincident with the new outputs.
REQ-026 SHALL update outputs one cycle after clk1sec (single-cycle latency); no combinational input-to-output path.
REQ-027 SHALL register alarm_time on alarm_load; alarm_load has no ordering interaction with set_time or clk1sec.
REQ-028 SHALL assert alarm_pulse for one cycle, coincident with outputs, when a clk1sec advance produces hour/minute/second equal to the stored alarm and alarm_en==1; a set_time load never fires the alarm.
REQ-029 SHALL hold all state when neither set_time nor clk1sec is asserted; all pulses are 0 then.

Reset
REQ-030 SHALL, while rst==1 at an edge, load RST_YEAR, RST_MONTH, RST_DAY, 0:00:00, RST_DOW, alarm register 0, all pulses 0; rst overrides set_time, clk1sec, alarm_load.
REQ-031 SHALL, on reset mid-operation, abandon any pending pulse; first tick after release advances from the reset time.

Verification
REQ-032 SHALL cover: set 2023-12-31 23:59:59, dow 0, then clk1sec -> 2024-01-01 00:00:00, dow 1.
REQ-033 SHALL cover: set 2024-02-28 23:59:59, tick -> 2024-02-29; set 2100-02-28 23:59:59, tick -> 2100-03-01.
REQ-034 SHALL cover: set 2023-02-29 12:00:00 -> set_err one cycle, outputs unchanged; also hour=24 -> set_err.
REQ-035 SHALL cover: set 4095-12-31 23:59:59, tick -> 0001-01-01 00:00:00 with wrap_pulse one cycle.
REQ-036 SHALL cover: alarm 07:30:00, alarm_en=1, time 07:29:59, tick -> alarm_pulse one cycle; same with alarm_en=0 -> no pulse; set directly to 07:30:00 -> no pulse.
REQ-037 SHALL cover: set_time and clk1sec same cycle -> loaded value exactly, no extra second; rst mid-count -> 2021-05-30 00:00:00, dow 0.

Source files
------------

// File: rtl/watch_datetime.sv
// Calendar watch: seconds-to-years timekeeping with leap years, weekday, validated
// time set, alarm match and year-wrap pulses. All outputs are registered.
module watch_datetime #(
    parameter int YEAR_W    = 12,
    parameter int YEAR_MIN  = 1,
    parameter int YEAR_MAX  = 4095,
    parameter int RST_YEAR  = 2021,
    parameter int RST_MONTH = 5,
    parameter int RST_DAY   = 30,
    parameter int RST_DOW   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk1sec,
    input  logic              set_time,
    input  logic [YEAR_W+39:0] bin_time,
    input  logic [2:0]        set_dow,
    input  logic              alarm_load,
    input  logic [23:0]       alarm_time,
    input  logic              alarm_en,
    output logic [YEAR_W-1:0] year,
    output logic [7:0]        month,
    output logic [7:0]        day,
    output logic [7:0]        hour,
    output logic [7:0]        minute,
    output logic [7:0]        second,
    output logic [2:0]        dow,
    output logic              set_err,
    output logic              alarm_pulse,
    output logic              wrap_pulse
);

    localparam logic [YEAR_W-1:0] YMIN = YEAR_W'(YEAR_MIN);
    localparam logic [YEAR_W-1:0] YMAX = YEAR_W'(YEAR_MAX);

    function automatic logic is_leap(input logic [YEAR_W-1:0] y);
        logic [31:0] yw;
        yw = 32'(y);
        return (((yw % 32'd4) == 32'd0) && ((yw % 32'd100) != 32'd0)) ||
               ((yw % 32'd400) == 32'd0);
    endfunction

    function automatic logic [7:0] max_day(input logic [YEAR_W-1:0] y, input logic [7:0] m);
        logic [7:0] md;
        case (m)
            8'd4, 8'd6, 8'd9, 8'd11: md = 8'd30;
            8'd2:                    md = is_leap(y) ? 8'd29 : 8'd28;
            default:                 md = 8'd31;
        endcase
        return md;
    endfunction

    logic [YEAR_W-1:0] year_q, year_d;
    logic [7:0]        month_q, month_d, day_q, day_d;
    logic [7:0]        hour_q, hour_d, minute_q, minute_d, second_q, second_d;
    logic [2:0]        dow_q, dow_d;
    logic [23:0]       alarm_q, alarm_d;
    logic              set_err_q, set_err_d, alarm_pulse_q, alarm_pulse_d;
    logic              wrap_pulse_q, wrap_pulse_d;

    logic [YEAR_W-1:0] bin_year_s;
    logic [7:0]        bin_month_s, bin_day_s, bin_hour_s, bin_minute_s, bin_second_s;
    logic              set_valid_s;

    assign bin_year_s   = bin_time[YEAR_W+39:40];
    assign bin_month_s  = bin_time[39:32];
    assign bin_day_s    = bin_time[31:24];
    assign bin_hour_s   = bin_time[23:16];
    assign bin_minute_s = bin_time[15:8];
    assign bin_second_s = bin_time[7:0];

    // Range check of a requested set; year bounds compared at 32 bits so the
    // check stays meaningful whatever YEAR_MIN/YEAR_MAX are chosen.
    assign set_valid_s = (32'(bin_year_s) >= 32'(YEAR_MIN)) &&
                         (32'(bin_year_s) <= 32'(YEAR_MAX)) &&
                         (bin_month_s >= 8'd1) && (bin_month_s <= 8'd12) &&
                         (bin_day_s >= 8'd1) &&
                         (bin_day_s <= max_day(bin_year_s, bin_month_s)) &&
                         (bin_hour_s <= 8'd23) && (bin_minute_s <= 8'd59) &&
                         (bin_second_s <= 8'd59) && (set_dow <= 3'd6);

    // Next-state: set beats tick, tick carries through the calendar.
    always_comb begin
        year_d        = year_q;
        month_d       = month_q;
        day_d         = day_q;
        hour_d        = hour_q;
        minute_d      = minute_q;
        second_d      = second_q;
        dow_d         = dow_q;
        set_err_d     = 1'b0;
        alarm_pulse_d = 1'b0;
        wrap_pulse_d  = 1'b0;

        if (alarm_load) begin
            alarm_d = alarm_time;
        end else begin
            alarm_d = alarm_q;
        end

        if (set_time) begin
            if (set_valid_s) begin
                year_d   = bin_year_s;
                month_d  = bin_month_s;
                day_d    = bin_day_s;
                hour_d   = bin_hour_s;
                minute_d = bin_minute_s;
                second_d = bin_second_s;
                dow_d    = set_dow;
            end else begin
                set_err_d = 1'b1;
            end
        end else if (clk1sec) begin
            if (second_q != 8'd59) begin
                second_d = second_q + 8'd1;
            end else begin
                second_d = 8'd0;
                if (minute_q != 8'd59) begin
                    minute_d = minute_q + 8'd1;
                end else begin
                    minute_d = 8'd0;
                    if (hour_q != 8'd23) begin
                        hour_d = hour_q + 8'd1;
                    end else begin
                        hour_d = 8'd0;
                        dow_d  = (dow_q >= 3'd6) ? 3'd0 : dow_q + 3'd1;
                        if (day_q < max_day(year_q, month_q)) begin
                            day_d = day_q + 8'd1;
                        end else begin
                            day_d = 8'd1;
                            if (month_q < 8'd12) begin
                                month_d = month_q + 8'd1;
                            end else begin
                                month_d = 8'd1;
                                if (year_q >= YMAX) begin
                                    year_d       = YMIN;
                                    wrap_pulse_d = 1'b1;
                                end else begin
                                    year_d = year_q + YEAR_W'(1);
                                end
                            end
                        end
                    end
                end
            end
            alarm_pulse_d = alarm_en && ({hour_d, minute_d, second_d} == alarm_q);
        end else begin
            set_err_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            year_q        <= YEAR_W'(RST_YEAR);
            month_q       <= 8'(RST_MONTH);
            day_q         <= 8'(RST_DAY);
            hour_q        <= 8'd0;
            minute_q      <= 8'd0;
            second_q      <= 8'd0;
            dow_q         <= 3'(RST_DOW);
            alarm_q       <= 24'd0;
            set_err_q     <= 1'b0;
            alarm_pulse_q <= 1'b0;
            wrap_pulse_q  <= 1'b0;
        end else begin
            year_q        <= year_d;
            month_q       <= month_d;
            day_q         <= day_d;
            hour_q        <= hour_d;
            minute_q      <= minute_d;
            second_q      <= second_d;
            dow_q         <= dow_d;
            alarm_q       <= alarm_d;
            set_err_q     <= set_err_d;
            alarm_pulse_q <= alarm_pulse_d;
            wrap_pulse_q  <= wrap_pulse_d;
        end
    end

    assign year        = year_q;
    assign month       = month_q;
    assign day         = day_q;
    assign hour        = hour_q;
    assign minute      = minute_q;
    assign second      = second_q;
    assign dow         = dow_q;
    assign set_err     = set_err_q;
    assign alarm_pulse = alarm_pulse_q;
    assign wrap_pulse  = wrap_pulse_q;

endmodule

// File: tb/tb_watch_datetime.sv
// Scoreboard bench for watch_datetime: a calendar model predicts every cycle,
// a negedge monitor compares, plus directed calendar checks.
module tb_watch_datetime;

    localparam int YW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clk1sec = 1'b0;
    logic          set_time = 1'b0;
    logic [YW+39:0] bin_time = '0;
    logic [2:0]    set_dow = 3'd0;
    logic          alarm_load = 1'b0;
    logic [23:0]   alarm_time = 24'd0;
    logic          alarm_en = 1'b0;
    logic [YW-1:0] year;
    logic [7:0]    month, day, hour, minute, second;
    logic [2:0]    dow;
    logic          set_err, alarm_pulse, wrap_pulse;

    watch_datetime dut (
        .clk(clk), .rst(rst), .clk1sec(clk1sec), .set_time(set_time),
        .bin_time(bin_time), .set_dow(set_dow), .alarm_load(alarm_load),
        .alarm_time(alarm_time), .alarm_en(alarm_en),
        .year(year), .month(month), .day(day), .hour(hour), .minute(minute),
        .second(second), .dow(dow), .set_err(set_err),
        .alarm_pulse(alarm_pulse), .wrap_pulse(wrap_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [62:0] tv;
        logic        serr;
        logic        apul;
        logic        wrap;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    int          m_year, m_month, m_day, m_hour, m_min, m_sec, m_dow;
    logic [23:0] m_alarm;
    logic        m_serr, m_apul, m_wrap;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [62:0] mk_tv(input int y, mo, d, h, mi, s, dw);
        return {12'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s), 3'(dw)};
    endfunction

    function automatic int mdays(input int y, input int m);
        if (m == 2) begin
            if (y % 400 == 0) return 29;
            if (y % 100 == 0) return 28;
            return (y % 4 == 0) ? 29 : 28;
        end
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    task automatic model_step();
        int by, bmo, bd, bh, bmi, bs;
        logic ok;
        by  = int'(bin_time[51:40]);
        bmo = int'(bin_time[39:32]);
        bd  = int'(bin_time[31:24]);
        bh  = int'(bin_time[23:16]);
        bmi = int'(bin_time[15:8]);
        bs  = int'(bin_time[7:0]);
        m_serr = 1'b0; m_apul = 1'b0; m_wrap = 1'b0;
        if (rst) begin
            m_year = 2021; m_month = 5; m_day = 30;
            m_hour = 0; m_min = 0; m_sec = 0; m_dow = 0; m_alarm = 24'd0;
        end else begin
            if (set_time) begin
                ok = (by >= 1) && (by <= 4095) && (bmo >= 1) && (bmo <= 12) &&
                     (bd >= 1) && (bd <= mdays(by, bmo)) && (bh < 24) &&
                     (bmi < 60) && (bs < 60) && (set_dow < 3'd7);
                if (ok) begin
                    m_year = by; m_month = bmo; m_day = bd;
                    m_hour = bh; m_min = bmi; m_sec = bs; m_dow = int'(set_dow);
                end else begin
                    m_serr = 1'b1;
                end
            end else if (clk1sec) begin
                m_sec++;
                if (m_sec == 60) begin
                    m_sec = 0; m_min++;
                    if (m_min == 60) begin
                        m_min = 0; m_hour++;
                        if (m_hour == 24) begin
                            m_hour = 0; m_dow = (m_dow + 1) % 7; m_day++;
                            if (m_day > mdays(m_year, m_month)) begin
                                m_day = 1; m_month++;
                                if (m_month > 12) begin
                                    m_month = 1; m_year++;
                                    if (m_year > 4095) begin
                                        m_year = 1; m_wrap = 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end
                m_apul = alarm_en && (m_hour * 3600 + m_min * 60 + m_sec ==
                         int'(m_alarm[23:16]) * 3600 + int'(m_alarm[15:8]) * 60 + int'(m_alarm[7:0]));
            end
            if (alarm_load) m_alarm = alarm_time;
        end
    endtask

    task automatic cycle();
        exp_t e;
        @(posedge clk);
        model_step();
        e.tv = mk_tv(m_year, m_month, m_day, m_hour, m_min, m_sec, m_dow);
        e.serr = m_serr; e.apul = m_apul; e.wrap = m_wrap;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compares each settled DUT cycle against the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq("time", {1'b0, year, month, day, hour, minute, second, dow}, {1'b0, e.tv});
            check_eq("set_err", {63'd0, set_err}, {63'd0, e.serr});
            check_eq("alarm_pulse", {63'd0, alarm_pulse}, {63'd0, e.apul});
            check_eq("wrap_pulse", {63'd0, wrap_pulse}, {63'd0, e.wrap});
        end
    end

    task automatic do_set(input int y, mo, d, h, mi, s, dw, input bit tk);
        set_time = 1'b1;
        bin_time = {12'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s)};
        set_dow  = 3'(dw);
        clk1sec  = tk;
        cycle();
        set_time = 1'b0;
        clk1sec  = 1'b0;
    endtask

    task automatic do_tick(input int n);
        for (int i = 0; i < n; i++) begin
            clk1sec = 1'b1;
            cycle();
            clk1sec = 1'b0;
        end
    endtask

    task automatic do_idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_alarm(input int h, mi, s);
        alarm_load = 1'b1;
        alarm_time = {8'(h), 8'(mi), 8'(s)};
        cycle();
        alarm_load = 1'b0;
    endtask

    task automatic check_now(input string tag, input logic [62:0] exp);
        check_eq(tag, {1'b0, year, month, day, hour, minute, second, dow}, {1'b0, exp});
    endtask

    initial begin
        int y;
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        check_now("reset_state", mk_tv(2021, 5, 30, 0, 0, 0, 0));
        do_idle(2);

        do_set(2023, 12, 31, 23, 59, 59, 0, 1'b0);
        do_tick(1);
        check_now("new_year", mk_tv(2024, 1, 1, 0, 0, 0, 1));

        do_set(2024, 2, 28, 23, 59, 59, 3, 1'b0);
        do_tick(1);
        check_now("leap_feb29", mk_tv(2024, 2, 29, 0, 0, 0, 4));
        do_set(2100, 2, 28, 23, 59, 59, 0, 1'b0);
        do_tick(1);
        check_now("century_mar1", mk_tv(2100, 3, 1, 0, 0, 0, 1));

        do_set(2023, 2, 29, 12, 0, 0, 2, 1'b0);
        check_eq("bad_feb29_err", {63'd0, set_err}, 64'd1);
        check_now("bad_feb29_hold", mk_tv(2100, 3, 1, 0, 0, 0, 1));
        do_idle(1);
        check_eq("err_one_cycle", {63'd0, set_err}, 64'd0);
        do_set(2024, 6, 1, 24, 0, 0, 2, 1'b0);
        do_set(2024, 6, 1, 0, 0, 0, 7, 1'b0);

        do_set(4095, 12, 31, 23, 59, 59, 5, 1'b0);
        do_tick(1);
        check_now("year_wrap", mk_tv(1, 1, 1, 0, 0, 0, 6));
        check_eq("wrap_seen", {63'd0, wrap_pulse}, 64'd1);
        do_tick(1);

        do_alarm(7, 30, 0);
        alarm_en = 1'b1;
        do_set(2024, 3, 10, 7, 29, 59, 0, 1'b0);
        do_tick(1);
        check_eq("alarm_fire", {63'd0, alarm_pulse}, 64'd1);
        do_tick(1);
        alarm_en = 1'b0;
        do_set(2024, 3, 10, 7, 29, 59, 0, 1'b0);
        do_tick(1);
        alarm_en = 1'b1;
        do_set(2024, 3, 10, 7, 30, 0, 0, 1'b0);
        check_eq("alarm_on_set", {63'd0, alarm_pulse}, 64'd0);
        do_idle(1);

        do_set(2022, 8, 15, 10, 20, 30, 1, 1'b1);
        check_now("set_beats_tick", mk_tv(2022, 8, 15, 10, 20, 30, 1));
        do_tick(5);
        do_idle(1);
        rst = 1'b1; set_time = 1'b1; clk1sec = 1'b1; alarm_load = 1'b1;
        alarm_time = {8'd0, 8'd0, 8'd1};
        cycle();
        rst = 1'b0; set_time = 1'b0; clk1sec = 1'b0; alarm_load = 1'b0;
        check_now("reset_mid", mk_tv(2021, 5, 30, 0, 0, 0, 0));
        do_tick(1);
        check_now("tick_after_rst", mk_tv(2021, 5, 30, 0, 0, 1, 0));

        do_alarm(23, 59, 30);
        do_set(1999, 12, 31, 23, 59, 0, 6, 1'b0);
        do_tick(90);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0: y = 1;
                1: y = 4095;
                2: y = 2000;
                3: y = 1900;
                4: y = 0;
                default: y = int'($urandom_range(1, 4095));
            endcase
            alarm_en = 1'(($urandom_range(0, 1)));
            alarm_load = 1'(($urandom_range(0, 3) == 0));
            alarm_time = {8'(($urandom_range(0, 23))), 8'(($urandom_range(0, 59))), 8'(($urandom_range(0, 59)))};
            do_set(y, int'($urandom_range(0, 13)), int'($urandom_range(0, 32)),
                   int'($urandom_range(22, 24)), int'($urandom_range(58, 60)),
                   int'($urandom_range(57, 60)), int'($urandom_range(0, 7)),
                   1'(($urandom_range(0, 1))));
            alarm_load = 1'b0;
            do_tick(int'($urandom_range(0, 4)));
            do_idle(int'($urandom_range(0, 1)));
        end

        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
